// File: rtl/int_alu_pipe.sv
// -----------------------------------------------------------------------------
// int_alu_pipe
//
// Pipelined integer ALU functional unit sitting between issue and the CDB
// arbiter. Takes one Alpha operate-format (non-branch) instruction per cycle,
// computes it, and carries the result through LAT register stages. The last
// stage holds its result until the CDB grants it; back-pressure collapses
// bubbles so issue only stalls when every stage is occupied. A flush squashes
// every in-flight op on the next edge.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start_i         issue valid; only legal while ready_o=1
//   ready_o         unit can accept an op this cycle (combinational)
//   opa_i, opb_i    operands (opb_i replaced by the literal when inst_i[12]=1)
//   inst_i          Alpha operate-format instruction
//   dest_tag_i      destination physical register tag
//   rob_idx_i       ROB entry of the op
//   flush_i         squash all in-flight ops, drop this cycle's accept
//   cdb_gnt_i       CDB took the current output this cycle
//   done_o          output stage holds a valid result
//   result_o        result
//   dest_tag_o      tag of result
//   rob_idx_o       ROB entry of result
//   illegal_o       function code unsupported (qualified by done_o)
//   inflight_o      number of valid stages
// -----------------------------------------------------------------------------
module int_alu_pipe #(
    parameter int XLEN      = 64,
    parameter int LAT       = 2,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    output logic                     ready_o,
    input  logic [XLEN-1:0]          opa_i,
    input  logic [XLEN-1:0]          opb_i,
    input  logic [31:0]              inst_i,
    input  logic [PRF_IDX_W-1:0]     dest_tag_i,
    input  logic [ROB_IDX_W-1:0]     rob_idx_i,
    input  logic                     flush_i,
    input  logic                     cdb_gnt_i,
    output logic                     done_o,
    output logic [XLEN-1:0]          result_o,
    output logic [PRF_IDX_W-1:0]     dest_tag_o,
    output logic [ROB_IDX_W-1:0]     rob_idx_o,
    output logic                     illegal_o,
    output logic [$clog2(LAT+1)-1:0] inflight_o
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(LAT+1);

    // Alpha operate-format major opcodes
    localparam logic [5:0] OP_INTA = 6'h10;  // arithmetic / compare
    localparam logic [5:0] OP_INTL = 6'h11;  // logical
    localparam logic [5:0] OP_SHFT = 6'h12;  // shifts

    // Alpha function codes (inst[11:5])
    localparam logic [6:0] F_ADDQ   = 7'h20;
    localparam logic [6:0] F_SUBQ   = 7'h29;
    localparam logic [6:0] F_CMPULT = 7'h1d;
    localparam logic [6:0] F_CMPEQ  = 7'h2d;
    localparam logic [6:0] F_CMPULE = 7'h3d;
    localparam logic [6:0] F_CMPLT  = 7'h4d;
    localparam logic [6:0] F_CMPLE  = 7'h6d;
    localparam logic [6:0] F_AND    = 7'h00;
    localparam logic [6:0] F_BIC    = 7'h08;
    localparam logic [6:0] F_BIS    = 7'h20;
    localparam logic [6:0] F_ORNOT  = 7'h28;
    localparam logic [6:0] F_XOR    = 7'h40;
    localparam logic [6:0] F_EQV    = 7'h48;
    localparam logic [6:0] F_SRL    = 7'h34;
    localparam logic [6:0] F_SLL    = 7'h39;
    localparam logic [6:0] F_SRA    = 7'h3c;

    localparam logic [63:0] BAD_RESULT = 64'hdeadbeefbaadbeef;

    typedef struct packed {
        logic [XLEN-1:0]      result;
        logic [PRF_IDX_W-1:0] tag;
        logic [ROB_IDX_W-1:0] rob;
        logic                 illegal;
    } stage_t;

    logic [LAT-1:0] valid;   // per-stage valid bits, S(LAT-1) is the output stage
    logic [LAT-1:0] adv;     // stage moves its op onward this cycle
    logic [LAT-1:0] space;   // stage can take an op this cycle (empty or advancing)
    stage_t         st [LAT];
    stage_t         alu_out;
    logic           accept;
    logic [CNT_W-1:0] inflight_q;

    // ---------------------------------------------------------------- ALU ---
    logic [XLEN-1:0] opb_eff;
    logic [SH_W-1:0] shamt;
    logic [12:0]     sel;

    // ADDQ and BIS share a function code, so the major opcode is part of the
    // decode key; non-operate opcodes fall into the illegal default.
    assign sel     = {inst_i[31:26], inst_i[11:5]};
    assign opb_eff = inst_i[12] ? XLEN'(inst_i[20:13]) : opb_i;
    assign shamt   = opb_eff[SH_W-1:0];

    // Register-number fields are not needed here; operands arrive pre-read.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_i[25:21], inst_i[4:0]};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        alu_out         = '0;
        alu_out.tag     = dest_tag_i;
        alu_out.rob     = rob_idx_i;
        unique case (sel)
            {OP_INTA, F_ADDQ}:   alu_out.result = opa_i + opb_eff;
            {OP_INTA, F_SUBQ}:   alu_out.result = opa_i - opb_eff;
            {OP_INTA, F_CMPULT}: alu_out.result = XLEN'(opa_i < opb_eff);
            {OP_INTA, F_CMPULE}: alu_out.result = XLEN'(opa_i <= opb_eff);
            {OP_INTA, F_CMPEQ}:  alu_out.result = XLEN'(opa_i == opb_eff);
            {OP_INTA, F_CMPLT}:  alu_out.result = XLEN'($signed(opa_i) <  $signed(opb_eff));
            {OP_INTA, F_CMPLE}:  alu_out.result = XLEN'($signed(opa_i) <= $signed(opb_eff));
            {OP_INTL, F_AND}:    alu_out.result = opa_i & opb_eff;
            {OP_INTL, F_BIC}:    alu_out.result = opa_i & ~opb_eff;
            {OP_INTL, F_BIS}:    alu_out.result = opa_i | opb_eff;
            {OP_INTL, F_ORNOT}:  alu_out.result = opa_i | ~opb_eff;
            {OP_INTL, F_XOR}:    alu_out.result = opa_i ^ opb_eff;
            {OP_INTL, F_EQV}:    alu_out.result = ~(opa_i ^ opb_eff);
            {OP_SHFT, F_SRL}:    alu_out.result = opa_i >> shamt;
            {OP_SHFT, F_SLL}:    alu_out.result = opa_i << shamt;
            {OP_SHFT, F_SRA}:    alu_out.result = $unsigned($signed(opa_i) >>> shamt);
            default: begin
                alu_out.result  = XLEN'(BAD_RESULT);
                alu_out.illegal = 1'b1;
            end
        endcase
    end

    // ----------------------------------------------------- advance control ---
    // Resolved from the output stage backwards: a stage advances when the
    // stage after it has space, so bubbles collapse under back-pressure.
    always_comb begin
        adv            = '0;
        space          = '0;
        adv[LAT-1]     = valid[LAT-1] & cdb_gnt_i;
        space[LAT-1]   = ~valid[LAT-1] | adv[LAT-1];
        for (int i = LAT-2; i >= 0; i--) begin
            adv[i]   = valid[i] & space[i+1];
            space[i] = ~valid[i] | adv[i];
        end
    end

    // Flush forces ready high; the accept that cycle is dropped anyway.
    assign ready_o = space[0] | flush_i;
    assign accept  = start_i & space[0] & ~flush_i;

    // ------------------------------------------------------------- stages ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: stage payloads are reset too, not just the valids, because
            // the output stage drives the ports directly and must read zero
            // after reset.
            valid <= '0;
            for (int i = 0; i < LAT; i++) st[i] <= '0;
        end else if (flush_i) begin
            valid <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read its
            // predecessor's old contents, so ops shift by exactly one stage.
            if (space[0]) begin
                valid[0] <= accept;
                if (accept) st[0] <= alu_out;
            end
            for (int i = 1; i < LAT; i++) begin
                if (space[i]) begin
                    valid[i] <= adv[i-1];
                    if (adv[i-1]) st[i] <= st[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       inflight_q <= '0;
        else if (flush_i) inflight_q <= '0;
        else              inflight_q <= inflight_q + CNT_W'(accept) - CNT_W'(adv[LAT-1]);
    end

    // ------------------------------------------------------------ outputs ---
    assign done_o     = valid[LAT-1];
    assign result_o   = st[LAT-1].result;
    assign dest_tag_o = st[LAT-1].tag;
    assign rob_idx_o  = st[LAT-1].rob;
    assign illegal_o  = st[LAT-1].illegal;
    assign inflight_o = inflight_q;

endmodule

// File: tb/tb_int_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_int_alu_pipe
//
// Directed bench for int_alu_pipe at XLEN=64, LAT=2. Inputs are driven 1 ns
// after the rising edge; outputs are checked there or mid-cycle, away from
// the active edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_int_alu_pipe;

    localparam int XLEN = 64;
    localparam int LAT  = 2;
    localparam int PW   = 6;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic            ready_o;
    logic [XLEN-1:0] opa_i = '0;
    logic [XLEN-1:0] opb_i = '0;
    logic [31:0]     inst_i = '0;
    logic [PW-1:0]   dest_tag_i = '0;
    logic [RW-1:0]   rob_idx_i = '0;
    logic            flush_i = 1'b0;
    logic            cdb_gnt_i = 1'b0;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [PW-1:0]   dest_tag_o;
    logic [RW-1:0]   rob_idx_o;
    logic            illegal_o;
    logic [$clog2(LAT+1)-1:0] inflight_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    int_alu_pipe #(.XLEN(XLEN), .LAT(LAT), .PRF_IDX_W(PW), .ROB_IDX_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .ready_o    (ready_o),
        .opa_i      (opa_i),
        .opb_i      (opb_i),
        .inst_i     (inst_i),
        .dest_tag_i (dest_tag_i),
        .rob_idx_i  (rob_idx_i),
        .flush_i    (flush_i),
        .cdb_gnt_i  (cdb_gnt_i),
        .done_o     (done_o),
        .result_o   (result_o),
        .dest_tag_o (dest_tag_o),
        .rob_idx_o  (rob_idx_o),
        .illegal_o  (illegal_o),
        .inflight_o (inflight_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Build an operate-format instruction; imm=1 uses the 8-bit literal.
    function automatic logic [31:0] mk(input logic [5:0] op, input logic [6:0] fn,
                                       input logic imm, input logic [7:0] lit);
        logic [31:0] w;
        w        = '0;
        w[31:26] = op;
        w[12]    = imm;
        w[11:5]  = fn;
        if (imm) w[20:13] = lit;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] a, input logic [63:0] b,
                         input logic [PW-1:0] tag, input logic [RW-1:0] rob);
        start_i    = 1'b1;
        inst_i     = inst;
        opa_i      = a;
        opb_i      = b;
        dest_tag_i = tag;
        rob_idx_i  = rob;
    endtask

    // One op with grant held: result visible two cycles after issue.
    task automatic run_op(input string tag, input logic [31:0] inst, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input logic exp_ill);
        cdb_gnt_i = 1'b1;
        drive(inst, a, b, 6'd5, 5'd2);
        tick();
        start_i = 1'b0;
        tick();
        check({tag, ".done"}, 64'(done_o), 64'd1);
        check({tag, ".result"}, result_o, exp);
        check({tag, ".illegal"}, 64'(illegal_o), 64'(exp_ill));
        tick();
    endtask

    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hffff_ffff_ffff_ffff;

    // Streaming table
    localparam int NS = 8;
    logic [31:0] s_inst [NS];
    logic [63:0] s_a [NS], s_b [NS], s_exp [NS];

    initial begin
        // ---- reset ----
        #1;
        check("rst.done", 64'(done_o), 64'd0);
        check("rst.result", result_o, 64'd0);
        check("rst.tag", 64'(dest_tag_o), 64'd0);
        check("rst.rob", 64'(rob_idx_o), 64'd0);
        check("rst.illegal", 64'(illegal_o), 64'd0);
        check("rst.inflight", 64'(inflight_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst.ready", 64'(ready_o), 64'd1);

        // ---- basic ADDQ latency ----
        cdb_gnt_i = 1'b1;
        drive(mk(6'h10, 7'h20, 1'b0, 8'd0), 64'd5, 64'd7, 6'd3, 5'd9);
        tick();
        start_i = 1'b0;
        check("add.done_early", 64'(done_o), 64'd0);
        check("add.inflight1", 64'(inflight_o), 64'd1);
        tick();
        check("add.done", 64'(done_o), 64'd1);
        check("add.result", result_o, 64'd12);
        check("add.tag", 64'(dest_tag_o), 64'd3);
        check("add.rob", 64'(rob_idx_o), 64'd9);
        tick();
        check("add.drained", 64'(done_o), 64'd0);
        check("add.inflight0", 64'(inflight_o), 64'd0);

        // ---- per-op vectors ----
        run_op("sra_imm4", mk(6'h12, 7'h3c, 1'b1, 8'd4), MSB, 64'd0, 64'hf800_0000_0000_0000, 1'b0);
        run_op("sra_amt0", mk(6'h12, 7'h3c, 1'b0, 8'd0), MSB, 64'd0, MSB, 1'b0);
        run_op("srl_63", mk(6'h12, 7'h34, 1'b0, 8'd0), MSB, 64'd63, 64'd1, 1'b0);
        run_op("cmplt", mk(6'h10, 7'h4d, 1'b0, 8'd0), ONES, 64'd1, 64'd1, 1'b0);
        run_op("cmpult", mk(6'h10, 7'h1d, 1'b0, 8'd0), ONES, 64'd1, 64'd0, 1'b0);
        run_op("cmple", mk(6'h10, 7'h6d, 1'b0, 8'd0), 64'd1, 64'd1, 64'd1, 1'b0);
        run_op("subq_wrap", mk(6'h10, 7'h29, 1'b0, 8'd0), 64'd0, 64'd1, ONES, 1'b0);
        run_op("bic", mk(6'h11, 7'h08, 1'b0, 8'd0), 64'hff, 64'h0f, 64'hf0, 1'b0);
        run_op("eqv", mk(6'h11, 7'h48, 1'b0, 8'd0), 64'd0, 64'd0, ONES, 1'b0);
        run_op("addq_imm", mk(6'h10, 7'h20, 1'b1, 8'd5), 64'd10, 64'd999, 64'd15, 1'b0);
        run_op("unknown", mk(6'h10, 7'h7f, 1'b0, 8'd0), 64'd1, 64'd2, 64'hdeadbeefbaadbeef, 1'b1);

        // ---- back-pressure ----
        cdb_gnt_i = 1'b0;
        drive(mk(6'h10, 7'h20, 1'b0, 8'd0), 64'd1, 64'd1, 6'd1, 5'd1);  // A = 2
        tick();
        check("bp.ready_after1", 64'(ready_o), 64'd1);
        drive(mk(6'h10, 7'h20, 1'b0, 8'd0), 64'd2, 64'd2, 6'd2, 5'd2);  // B = 4
        tick();
        start_i = 1'b0;
        check("bp.ready_full", 64'(ready_o), 64'd0);
        check("bp.inflight2", 64'(inflight_o), 64'd2);
        check("bp.A_result", result_o, 64'd2);
        check("bp.A_tag", 64'(dest_tag_o), 64'd1);
        tick();
        check("bp.A_stable", result_o, 64'd2);
        // grant and accept together with a full pipe
        cdb_gnt_i = 1'b1;
        #1;
        check("bp.ready_gnt", 64'(ready_o), 64'd1);
        drive(mk(6'h10, 7'h20, 1'b0, 8'd0), 64'd3, 64'd3, 6'd3, 5'd3);  // C = 6
        tick();
        start_i   = 1'b0;
        cdb_gnt_i = 1'b0;
        check("bp.B_result", result_o, 64'd4);
        check("bp.B_tag", 64'(dest_tag_o), 64'd2);
        check("bp.inflight_swap", 64'(inflight_o), 64'd2);
        tick();
        check("bp.B_stable", result_o, 64'd4);
        cdb_gnt_i = 1'b1;
        tick();
        cdb_gnt_i = 1'b0;
        check("bp.C_result", result_o, 64'd6);
        check("bp.C_rob", 64'(rob_idx_o), 64'd3);
        check("bp.inflight1", 64'(inflight_o), 64'd1);
        cdb_gnt_i = 1'b1;
        tick();
        check("bp.empty", 64'(done_o), 64'd0);
        check("bp.inflight0", 64'(inflight_o), 64'd0);

        // ---- flush ----
        cdb_gnt_i = 1'b0;
        drive(mk(6'h10, 7'h20, 1'b0, 8'd0), 64'd10, 64'd1, 6'd4, 5'd4);
        tick();
        drive(mk(6'h10, 7'h20, 1'b0, 8'd0), 64'd20, 64'd1, 6'd5, 5'd5);
        tick();
        check("fl.inflight2", 64'(inflight_o), 64'd2);
        flush_i = 1'b1;
        drive(mk(6'h10, 7'h20, 1'b0, 8'd0), 64'd30, 64'd1, 6'd6, 5'd6);
        #1;
        check("fl.ready", 64'(ready_o), 64'd1);
        tick();
        flush_i = 1'b0;
        start_i = 1'b0;
        check("fl.done", 64'(done_o), 64'd0);
        check("fl.inflight", 64'(inflight_o), 64'd0);
        tick();
        check("fl.no_ghost", 64'(done_o), 64'd0);
        run_op("fl.after", mk(6'h11, 7'h40, 1'b0, 8'd0), 64'hf0f0, 64'h0ff0, 64'hff00, 1'b0);

        // ---- streaming at 1 op/cycle ----
        s_inst[0] = mk(6'h10, 7'h20, 1'b0, 8'd0); s_a[0] = ONES;     s_b[0] = 64'd1;    s_exp[0] = 64'd0;
        s_inst[1] = mk(6'h11, 7'h40, 1'b0, 8'd0); s_a[1] = 64'hf0f0; s_b[1] = 64'h0ff0; s_exp[1] = 64'hff00;
        s_inst[2] = mk(6'h11, 7'h00, 1'b0, 8'd0); s_a[2] = 64'h1234; s_b[2] = 64'h00ff; s_exp[2] = 64'h34;
        s_inst[3] = mk(6'h12, 7'h39, 1'b1, 8'd8); s_a[3] = 64'd1;    s_b[3] = 64'd0;    s_exp[3] = 64'h100;
        s_inst[4] = mk(6'h10, 7'h2d, 1'b0, 8'd0); s_a[4] = 64'd7;    s_b[4] = 64'd7;    s_exp[4] = 64'd1;
        s_inst[5] = mk(6'h11, 7'h20, 1'b0, 8'd0); s_a[5] = 64'ha0;   s_b[5] = 64'h05;   s_exp[5] = 64'ha5;
        s_inst[6] = mk(6'h11, 7'h28, 1'b0, 8'd0); s_a[6] = 64'd0;    s_b[6] = 64'hffff_ffff_ffff_ff00; s_exp[6] = 64'hff;
        s_inst[7] = mk(6'h10, 7'h3d, 1'b0, 8'd0); s_a[7] = 64'd3;    s_b[7] = 64'd3;    s_exp[7] = 64'd1;
        cdb_gnt_i = 1'b1;
        for (int c = 0; c <= NS; c++) begin
            if (c < NS) drive(s_inst[c], s_a[c], s_b[c], PW'(c), RW'(c));
            else        start_i = 1'b0;
            check($sformatf("st.ready%0d", c), 64'(ready_o), 64'd1);
            tick();
            if (c >= 1) begin
                check($sformatf("st.done%0d", c-1), 64'(done_o), 64'd1);
                check($sformatf("st.result%0d", c-1), result_o, s_exp[c-1]);
                check($sformatf("st.tag%0d", c-1), 64'(dest_tag_o), 64'(c-1));
            end
        end
        tick();
        check("st.empty", 64'(done_o), 64'd0);

        // ---- asynchronous reset while stalled ----
        cdb_gnt_i = 1'b0;
        drive(mk(6'h10, 7'h20, 1'b0, 8'd0), 64'd40, 64'd2, 6'd7, 5'd7);
        tick();
        start_i = 1'b0;
        tick();
        check("ar.done_before", 64'(done_o), 64'd1);
        check("ar.result_before", result_o, 64'd42);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.done", 64'(done_o), 64'd0);
        check("ar.result", result_o, 64'd0);
        check("ar.tag", 64'(dest_tag_o), 64'd0);
        check("ar.inflight", 64'(inflight_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("ar.no_completion", 64'(done_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
